// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit-side scheduler and its arbiter.
// Holds the FSM state encoding, the byte width and the default inter-packet gap.
package usb_tx_pkg;

    localparam int unsigned DW_BYTE     = 8;
    localparam int unsigned IPG_CYC_DEF = 96;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_PKT  = 2'd1;
    localparam logic [ST_W-1:0] ST_GAP  = 2'd2;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usb_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter, reused by the RX-side scheduler.
// Ports:
//   req  - request vector
//   ptr  - index with highest priority this cycle
//   gnt  - one-hot grant (all zero when no request)
//   idx  - binary index of the granted requester (0 when no request)
module rr_arbiter
    import usb_tx_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [N-1:0]          gnt,
    output logic [idx_w(N)-1:0]   idx
);

    localparam int unsigned IW = idx_w(N);

    logic found;

    // Scan requesters in order ptr, ptr+1, ... (mod N); first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && (j == ((32'(ptr) + k) % N)) && req[j]) begin
                    gnt[j] = 1'b1;
                    idx    = IW'(j);
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/usb_tx_sched.sv
// Packet-level scheduler sharing one phy_tx byte port between NUM_REQ sources.
// A whole packet (sop..eop) is granted to one requester and passed through,
// then the bus stays quiet for IPG_CYC cycles while phy_tx finishes the EOP.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_sop/eop/valid/data   - per-requester byte stream (byte i at [8i+7:8i])
//   req_ready                - per-requester byte accepted (or flushed)
//   tx_sop/eop/valid/data    - byte stream to phy_tx
//   tx_ready                 - phy_tx accepts byte when tx_valid && tx_ready
//   busy                     - registered, high in PKT or GAP
//   grant_id                 - registered current/last owner index
//   err_nosop                - pulse when a non-owner byte without sop is flushed
module usb_tx_sched
    import usb_tx_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IPG_CYC = IPG_CYC_DEF,
    parameter int unsigned DW      = DW_BYTE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_sop,
    input  logic [NUM_REQ-1:0]      req_eop,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*DW-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    tx_sop,
    output logic                    tx_eop,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [DW-1:0]           tx_data,
    output logic                    busy,
    output logic [1:0]              grant_id,
    output logic                    err_nosop
);

    localparam int unsigned IW = idx_w(NUM_REQ);
    localparam int unsigned GW = $clog2(IPG_CYC + 1);

    logic [ST_W-1:0] state_q,    state_d;
    logic [IW-1:0]   owner_q,    owner_d;
    logic [IW-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [GW-1:0]   gap_cnt_q,  gap_cnt_d;
    logic            busy_q,     busy_d;
    logic [1:0]      grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;

    logic               own_valid;
    logic               own_sop;
    logic               own_eop;
    logic [DW-1:0]      own_data;

    assign cand = req_valid & req_sop;

    rr_arbiter #(
        .N   (NUM_REQ)
    ) u_arb (
        .req (cand),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Select the owner's byte stream.
    always_comb begin
        own_valid = 1'b0;
        own_sop   = 1'b0;
        own_eop   = 1'b0;
        own_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IW'(i)) begin
                own_valid = req_valid[i];
                own_sop   = req_sop[i];
                own_eop   = req_eop[i];
                own_data  = req_data[i*DW +: DW];
            end
        end
    end

    // Next-state, pass-through and flush logic.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        gap_cnt_d  = gap_cnt_q;
        grant_id_d = grant_id_q;
        tx_sop     = 1'b0;
        tx_eop     = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        req_ready  = '0;
        err_nosop  = 1'b0;

        // Mid-packet bytes from a non-owner can never be sent; drop them.
        // In IDLE nobody owns the bus, so every requester is a non-owner.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !req_sop[i] &&
                ((state_q == ST_IDLE) || ((state_q == ST_PKT) && (owner_q != IW'(i))))) begin
                req_ready[i] = 1'b1;
                err_nosop    = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    owner_d    = arb_idx;
                    rr_ptr_d   = (32'(arb_idx) == (NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
                    grant_id_d = 2'(arb_idx);
                    state_d    = ST_PKT;
                end
            end
            ST_PKT: begin
                tx_sop   = own_sop;
                tx_eop   = own_eop;
                tx_valid = own_valid;
                tx_data  = own_data;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (owner_q == IW'(i)) begin
                        req_ready[i] = tx_ready;
                    end
                end
                if (own_valid && tx_ready && own_eop) begin
                    gap_cnt_d = GW'(IPG_CYC - 1);
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            gap_cnt_q  <= gap_cnt_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Scoreboard bench for usb_tx_sched: stimulus pushes packets into per-requester
// queues, a negedge monitor runs a packet-level bus model and checks the DUT.
module tb_usb_tx_sched;

    localparam int NR  = 2;
    localparam int IPG = 12;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req_sop;
    logic [NR-1:0] req_eop;
    logic [NR-1:0] req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic          tx_sop;
    logic          tx_eop;
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          busy;
    logic [1:0]    grant_id;
    logic          err_nosop;

    beat_t beat_q [NR][$];
    beat_t exp_q  [NR][$];

    int n_chk;
    int n_fail;
    bit hold_drv;
    bit bubble_en;
    int rdy_mode;

    usb_tx_sched #(
        .NUM_REQ   (NR),
        .IPG_CYC   (IPG),
        .DW        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_sop   (req_sop),
        .req_eop   (req_eop),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id),
        .err_nosop (err_nosop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int r, input int len, input bit junk_first,
                            input bit use_fixed, input logic [63:0] fixed);
        beat_t b;
        if (junk_first) begin
            b.data = 8'($urandom);
            b.sop  = 1'b0;
            b.eop  = 1'b0;
            beat_q[r].push_back(b);
        end
        for (int i = 0; i < len; i++) begin
            b.data = use_fixed ? fixed[i*8 +: 8] : 8'($urandom);
            b.sop  = (i == 0);
            b.eop  = (i == len - 1);
            beat_q[r].push_back(b);
            exp_q[r].push_back(b);
        end
    endtask

    task automatic push_junk(input int r, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = 8'($urandom);
            b.sop  = 1'b0;
            b.eop  = 1'b0;
            beat_q[r].push_back(b);
        end
    endtask

    task automatic wait_drain(input string name);
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            empty = 1'b1;
            for (int r = 0; r < NR; r++) begin
                if (beat_q[r].size() != 0 || exp_q[r].size() != 0) empty = 1'b0;
            end
            if (empty) break;
        end
        chk(name, 32'(empty), 32'd1);
        repeat (IPG + 3) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
        chk({tag, "_tx_sop"},    32'(tx_sop),    32'd0);
        chk({tag, "_tx_eop"},    32'(tx_eop),    32'd0);
        chk({tag, "_tx_data"},   32'(tx_data),   32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_grant_id"},  32'(grant_id),  32'd0);
        chk({tag, "_err_nosop"}, 32'(err_nosop), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    // Requester and phy_tx drivers: present queue heads, pop on handshake.
    initial begin : drv
        logic [NR-1:0] acc;
        int ph;
        ph        = 0;
        req_sop   = '0;
        req_eop   = '0;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int r = 0; r < NR; r++) begin
                if (acc[r] && beat_q[r].size() != 0) void'(beat_q[r].pop_front());
                if (!hold_drv && beat_q[r].size() != 0 &&
                    !(bubble_en && $urandom_range(0, 3) == 0)) begin
                    req_valid[r]        = 1'b1;
                    req_sop[r]          = beat_q[r][0].sop;
                    req_eop[r]          = beat_q[r][0].eop;
                    req_data[r*8 +: 8]  = beat_q[r][0].data;
                end else begin
                    req_valid[r]        = 1'b0;
                    req_sop[r]          = 1'b0;
                    req_eop[r]          = 1'b0;
                    req_data[r*8 +: 8]  = 8'h00;
                end
            end
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: tx_ready = ($urandom_range(0, 9) < 7);
            endcase
            ph++;
        end
    end

    // Packet-level bus model and checker. A packet's eop in cycle T makes
    // cycle T+IPG+1 the first one where a new sop can win arbitration.
    int cyc;
    bit m_owned;
    int m_own;
    int m_rr;
    int m_last;
    int quiet_until;

    always @(negedge clk) begin : mon
        int    phase;
        bit    exp_rdy;
        bit    exp_err;
        bit    found;
        int    cand_r;
        beat_t e;
        cyc++;
        if (rst) begin
            m_owned     = 1'b0;
            m_own       = 0;
            m_rr        = 0;
            m_last      = 0;
            quiet_until = cyc + 1;
        end else begin
            if (m_owned)                 phase = 1;
            else if (cyc >= quiet_until) phase = 0;
            else                         phase = 2;

            chk("busy", 32'(busy), 32'(phase != 0));
            chk("grant_id", 32'(grant_id), 32'(m_last));

            exp_err = 1'b0;
            for (int r = 0; r < NR; r++) begin
                if (phase == 1 && r == m_own) begin
                    chk("owner_ready", 32'(req_ready[r]), 32'(tx_ready));
                end else begin
                    exp_rdy = (phase != 2) && req_valid[r] && !req_sop[r];
                    exp_err = exp_err | exp_rdy;
                    chk("req_ready", 32'(req_ready[r]), 32'(exp_rdy));
                end
            end
            chk("err_nosop", 32'(err_nosop), 32'(exp_err));

            if (phase == 1) begin
                chk("tx_valid", 32'(tx_valid), 32'(req_valid[m_own]));
                if (req_valid[m_own] && tx_ready) begin
                    chk("exp_q_nonempty", 32'(exp_q[m_own].size() != 0), 32'd1);
                    if (exp_q[m_own].size() != 0) begin
                        e = exp_q[m_own].pop_front();
                        chk("tx_data", 32'(tx_data), 32'(e.data));
                        chk("tx_sop",  32'(tx_sop),  32'(e.sop));
                        chk("tx_eop",  32'(tx_eop),  32'(e.eop));
                    end
                    if (req_eop[m_own]) begin
                        m_owned     = 1'b0;
                        quiet_until = cyc + IPG + 1;
                    end
                end
            end else begin
                chk("tx_valid_quiet", 32'(tx_valid), 32'd0);
                if (phase == 0) begin
                    found = 1'b0;
                    for (int k = 0; k < NR; k++) begin
                        cand_r = (m_rr + k) % NR;
                        if (!found && req_valid[cand_r] && req_sop[cand_r]) begin
                            found   = 1'b1;
                            m_owned = 1'b1;
                            m_own   = cand_r;
                            m_last  = cand_r;
                            m_rr    = (cand_r + 1) % NR;
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        bit seen;
        n_chk     = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        hold_drv  = 1'b0;
        bubble_en = 1'b0;
        rdy_mode  = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        // Single requester, fixed 4-byte packet.
        push_pkt(0, 4, 1'b0, 1'b1, 64'h0000_0000_FC0F_FF00);
        wait_drain("t1_drain");

        // Both requesters raise sop in the same cycle straight after reset.
        do_reset();
        push_pkt(0, 3, 1'b0, 1'b0, '0);
        push_pkt(1, 2, 1'b0, 1'b0, '0);
        wait_drain("t2_drain");

        // Back-to-back: req0 streams three packets, req1 has one pending.
        push_pkt(0, 2, 1'b0, 1'b0, '0);
        push_pkt(0, 3, 1'b0, 1'b0, '0);
        push_pkt(0, 1, 1'b0, 1'b0, '0);
        push_pkt(1, 2, 1'b0, 1'b0, '0);
        wait_drain("t3_drain");

        // tx_ready pattern 1,0,0,1.
        rdy_mode = 1;
        push_pkt(0, 6, 1'b0, 1'b0, '0);
        wait_drain("t4_drain");
        rdy_mode = 0;

        // Non-owner mid-packet bytes while req0 owns the bus.
        push_pkt(0, 8, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #2;
        push_junk(1, 3);
        wait_drain("t5_drain");

        // Reset during byte 2 of a 5-byte packet from req1.
        push_pkt(1, 5, 1'b0, 1'b0, '0);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready && tx_sop) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t6_sop_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #2;
        rst      = 1'b1;
        hold_drv = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int r = 0; r < NR; r++) begin
            beat_q[r].delete();
            exp_q[r].delete();
        end
        @(negedge clk);
        chk_all_zero("t6_after_rst");
        push_pkt(0, 3, 1'b0, 1'b0, '0);
        hold_drv = 1'b0;
        @(negedge clk);
        chk("t6_arb_cycle_tx_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        chk("t6_grant_tx_valid", 32'(tx_valid), 32'd1);
        chk("t6_grant_tx_sop", 32'(tx_sop), 32'd1);
        wait_drain("t6_drain");

        // Randomised traffic with bubbles, ready stalls and stray bytes.
        bubble_en = 1'b1;
        rdy_mode  = 2;
        for (int it = 0; it < 30; it++) begin
            for (int r = 0; r < NR; r++) begin
                if ($urandom_range(0, 3) != 0)
                    push_pkt(r, int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0), 1'b0, '0);
            end
            if ($urandom_range(0, 1) == 0) wait_drain("rnd_drain");
        end
        wait_drain("rnd_final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
